// File: rtl/seg7_pkg.sv
// Shared constants for the seg7_count_display slice: converter FSM encodings,
// active-low segment codes and the digit decoder used by the top level.
package seg7_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int         BIN_W     = 12;
    localparam logic [3:0] ITER_LAST = 4'd11;

    // Segment bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg7_count_display_bin2bcd.sv
// Sequential double-dabble converter: 12-bit binary to 4 BCD digits,
// one free-running conversion every 14 cycles (IDLE, 12x SHIFT, DONE).
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] bin,
    output logic [15:0]      bcd,
    output logic             bcd_valid
);

    logic [1:0]       state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [15:0]      acc_q, acc_d;
    logic [3:0]       iter_q, iter_d;
    logic [15:0]      adj;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        iter_d  = iter_q;
        adj     = acc_q;
        // Add-3 correction keeps each nibble a valid decimal digit after the shift.
        for (int i = 0; i < 4; i++) begin
            if (acc_q[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
            end
        end
        case (state_q)
            ST_IDLE: begin
                bin_d   = bin;
                acc_d   = 16'h0000;
                iter_d  = 4'd0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                {acc_d, bin_d} = {adj[14:0], bin_q, 1'b0};
                iter_d = iter_q + 4'd1;
                if (iter_q == ITER_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            acc_q   <= 16'h0000;
            iter_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            iter_q  <= iter_d;
        end
    end

    assign bcd       = acc_q;
    assign bcd_valid = (state_q == ST_DONE);

endmodule

// File: rtl/seg7_count_display.sv
// 4-digit multiplexed common-anode display of a 12-bit count in decimal.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg7_count_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int DIV_W       = 20
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] value,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [15:0]      bcd;
    logic             bcd_valid;
    logic [15:0]      disp_q, disp_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       digit;
    logic             blank;

    bin2bcd_seq u_bcd (
        .clk       (clk),
        .rst_n     (rst_n),
        .bin       (value),
        .bcd       (bcd),
        .bcd_valid (bcd_valid)
    );

    always_comb begin
        disp_d = bcd_valid ? bcd : disp_q;
        div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        idx_d  = (div_q == DIV_LAST) ? idx_q + 2'd1 : idx_q;
        digit  = 4'd0;
        blank  = 1'b0;
        case (idx_q)
            2'd0: digit = disp_q[3:0];
            2'd1: digit = disp_q[7:4];
            2'd2: digit = disp_q[11:8];
            default: digit = disp_q[15:12];
        endcase
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        // A digit is a leading zero when it and every digit above it are zero.
        case (idx_q)
            2'd1: blank = (disp_q[15:4] == 12'h000);
            2'd2: blank = (disp_q[15:8] == 8'h00);
            2'd3: blank = (disp_q[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
`endif
        an_d  = ~(4'b0001 << idx_q);
        seg_d = blank ? SEG_BLANK : seg_decode(digit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q <= 16'h0000;
            div_q  <= '0;
            idx_q  <= 2'd0;
            an_q   <= 4'b1111;
            seg_q  <= SEG_BLANK;
        end else begin
            disp_q <= disp_d;
            div_q  <= div_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_seg7_count_display.sv
// Self-checking bench for seg7_count_display: scan vectors, conversion
// scoreboard, mid-conversion reset and a full 0..4095 sweep.
module tb_seg7_count_display;

    localparam int R = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] value = 12'd0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    seg7_count_display #(.REFRESH_DIV(R), .DIV_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .value (value),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
    } scan_vec_t;

    scan_vec_t   vecs[$];
    logic [15:0] exp_q[$];
    logic [15:0] disp_exp = 16'h0000;
    int          mon_cyc = 0;
    bit          upd_pending = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          cur = 0;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] exp_seg(input int d);
        logic [6:0] s;
        case (d)
            0: s = 7'b1000000;  1: s = 7'b1111001;  2: s = 7'b0100100;
            3: s = 7'b0110000;  4: s = 7'b0011001;  5: s = 7'b0010010;
            6: s = 7'b0000010;  7: s = 7'b1111000;  8: s = 7'b0000000;
            9: s = 7'b0010000;  default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    endtask

    // Scoreboard: push the expected BCD at each capture edge, pop when DONE lands.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mon_cyc = 0;
            exp_q.delete();
            upd_pending = 1'b0;
            disp_exp = 16'h0000;
        end else begin
            mon_cyc++;
            if (mon_cyc % 14 == 1) exp_q.push_back(to_bcd(int'(value)));
            if (mon_cyc % 14 == 0) upd_pending = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (upd_pending) begin
                upd_pending = 1'b0;
                if (exp_q.size() == 0) check_val("scoreboard_empty", 16'h0001, 16'h0000);
                else disp_exp = exp_q.pop_front();
            end
            check_val("disp_reg", dut.disp_q, disp_exp);
        end
    end

    task automatic step_to(input int target);
        while (cur < target) begin
            @(negedge clk);
            cur++;
        end
    endtask

    task automatic apply_reset(input logic [11:0] v);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("rst_an", {12'h0, an}, 16'h000F);
        check_val("rst_seg", {9'h0, seg}, 16'h007F);
        check_val("rst_dp", {15'h0, dp}, 16'h0001);
        check_val("rst_disp", dut.disp_q, 16'h0000);
        value = v;
        @(negedge clk);
        rst_n = 1'b1;
        cur = 0;
    endtask

    task automatic add_vec(input int c, input logic [3:0] a, input logic [6:0] s);
        scan_vec_t t;
        t.cyc = c;
        t.an  = a;
        t.seg = s;
        vecs.push_back(t);
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            step_to(vecs[i].cyc);
            check_val({tag, "_an"}, {12'h0, an}, {12'h0, vecs[i].an});
            check_val({tag, "_seg"}, {9'h0, seg}, {9'h0, vecs[i].seg});
            check_val({tag, "_dp"}, {15'h0, dp}, 16'h0001);
        end
        vecs.delete();
    endtask

    logic [6:0] upper_zero;

    initial begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        upper_zero = 7'b1111111;
`else
        upper_zero = exp_seg(0);
`endif
        // Reset and first digit after release
        apply_reset(12'd0);
        step_to(1);
        check_val("post_rst_an", {12'h0, an}, 16'h000E);
        check_val("post_rst_seg", {9'h0, seg}, {9'h0, exp_seg(0)});

        // Max value scan
        apply_reset(12'd4095);
        add_vec(15, 4'b0111, exp_seg(4));
        add_vec(17, 4'b1110, exp_seg(5));
        add_vec(20, 4'b1110, exp_seg(5));
        add_vec(21, 4'b1101, exp_seg(9));
        add_vec(24, 4'b1101, exp_seg(9));
        add_vec(25, 4'b1011, exp_seg(0));
        add_vec(28, 4'b1011, exp_seg(0));
        add_vec(29, 4'b0111, exp_seg(4));
        add_vec(32, 4'b0111, exp_seg(4));
        add_vec(33, 4'b1110, exp_seg(5));
        run_vecs("max");

        // Value change right after capture is held off to the next conversion
        apply_reset(12'd123);
        step_to(1);
        value = 12'd456;
        step_to(20);
        check_val("hold_123", dut.disp_q, 16'h0123);
        step_to(30);
        check_val("next_456", dut.disp_q, 16'h0456);

        // Reset during SHIFT iteration 6 of the second conversion
        apply_reset(12'd999);
        step_to(20);
        apply_reset(12'd999);
        step_to(13);
        check_val("midrst_pending", dut.disp_q, 16'h0000);
        step_to(14);
        check_val("midrst_999", dut.disp_q, 16'h0999);

        // Leading-zero handling, value 7 then 0
        apply_reset(12'd7);
        add_vec(17, 4'b1110, exp_seg(7));
        add_vec(21, 4'b1101, upper_zero);
        add_vec(25, 4'b1011, upper_zero);
        add_vec(29, 4'b0111, upper_zero);
        run_vecs("lz7");
        apply_reset(12'd0);
        add_vec(17, 4'b1110, exp_seg(0));
        add_vec(21, 4'b1101, upper_zero);
        add_vec(25, 4'b1011, upper_zero);
        add_vec(29, 4'b0111, upper_zero);
        run_vecs("lz0");

        // Full sweep, one value per conversion period
        apply_reset(12'd0);
        for (int v = 0; v < 4096; v++) begin
            value = 12'(v);
            step_to(cur + 14);
        end
        step_to(cur + 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
